// File: rtl/actbuf_pingpong_ctrl.sv
// Ping-pong bank controller for the 2-write/1-read activation buffer.
// The RAM is split into a COMPUTE bank (streamed out to the array) and a FILL bank
// (written by the loader and by array writeback). A swap exchanges the two roles.
// Optional feature: define ACTBUF_BOUNDS_CHECK_EN to suppress out-of-bank accesses
// and raise a sticky err_o.
module actbuf_pingpong_ctrl #(
  parameter int unsigned addrWidth       = 32,
  parameter int unsigned dataSize        = 8,
  parameter int unsigned interfaceWidth1 = 32,
  parameter int unsigned interfaceWidth2 = 256,
  parameter int unsigned depth           = 1024,
  parameter int unsigned bankAw          = $clog2(depth / 2)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  input  logic [bankAw-1:0]          ld_addr_i,
  input  logic [interfaceWidth1-1:0] ld_data_i,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic [bankAw-1:0]          wb_addr_i,
  input  logic [interfaceWidth2-1:0] wb_data_i,
  input  logic                       rs_start_i,
  output logic                       rs_start_ready_o,
  input  logic [bankAw-1:0]          rs_base_i,
  input  logic [15:0]                rs_len_i,
  output logic                       rs_valid_o,
  input  logic                       rs_ready_i,
  output logic [interfaceWidth2-1:0] rs_data_o,
  output logic                       rs_busy_o,
  output logic                       rs_done_o,
  input  logic                       swap_req_i,
  output logic                       swap_ack_o,
  output logic                       bank_sel_o,
  output logic                       ram_wr_en_1_o,
  output logic [addrWidth-1:0]       ram_wr_addr_1_o,
  output logic [interfaceWidth1-1:0] ram_wr_data_1_o,
  output logic                       ram_wr_en_2_o,
  output logic [addrWidth-1:0]       ram_wr_addr_2_o,
  output logic [interfaceWidth2-1:0] ram_wr_data_2_o,
  output logic                       ram_rd_en_o,
  output logic [addrWidth-1:0]       ram_rd_addr_o,
  input  logic [interfaceWidth2-1:0] ram_data_i,
  output logic                       err_o
);

  localparam int unsigned Bank    = depth / 2;
  localparam int unsigned Stride  = interfaceWidth2 / dataSize;
  localparam int unsigned LdElems = interfaceWidth1 / dataSize;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                     state_q;
  logic                       bank_sel_q;
  logic                       ack_q;
  logic [bankAw-1:0]          off_q;
  logic [15:0]                rem_q;
  logic [1:0]                 cnt_q;
  logic                       inflight_q;
  logic                       wr_ptr_q;
  logic                       rd_ptr_q;
  logic [interfaceWidth2-1:0] fifo_mem [2];

  logic                       idle;
  logic                       pop;
  logic                       start_acc;
  logic                       done;
  logic                       ld_oob;
  logic                       wb_oob;
  logic                       start_oob;
  logic [2:0]                 occ;
  logic [addrWidth-1:0]       compute_base;
  logic [addrWidth-1:0]       fill_base;

  assign idle         = (state_q == StIdle);
  assign compute_base = bank_sel_q ? addrWidth'(Bank) : '0;
  assign fill_base    = bank_sel_q ? '0 : addrWidth'(Bank);

  // ack_q keeps a request held one cycle too long from toggling the banks twice
  assign swap_ack_o = swap_req_i & idle & ~ack_q;
  assign bank_sel_o = bank_sel_q;

`ifdef ACTBUF_BOUNDS_CHECK_EN
  assign ld_oob    = (32'(ld_addr_i) + 32'(LdElems)) > 32'(Bank);
  assign wb_oob    = (32'(wb_addr_i) + 32'(Stride)) > 32'(Bank);
  assign start_oob = (32'(rs_base_i) + 32'(rs_len_i) * 32'(Stride)) > 32'(Bank);
`else
  assign ld_oob    = 1'b0;
  assign wb_oob    = 1'b0;
  assign start_oob = 1'b0;
`endif

  // Write ports are pure pass-through into the FILL bank; nothing is accepted in the ack cycle
  assign ld_ready_o      = ~swap_ack_o;
  assign wb_ready_o      = ~swap_ack_o;
  assign ram_wr_en_1_o   = ld_valid_i & ld_ready_o & ~ld_oob;
  assign ram_wr_addr_1_o = fill_base + addrWidth'(ld_addr_i);
  assign ram_wr_data_1_o = ld_data_i;
  assign ram_wr_en_2_o   = wb_valid_i & wb_ready_o & ~wb_oob;
  assign ram_wr_addr_2_o = fill_base + addrWidth'(wb_addr_i);
  assign ram_wr_data_2_o = wb_data_i;

  // Swap has priority over a new stream
  assign rs_start_ready_o = idle & ~swap_req_i;
  assign start_acc        = rs_start_i & rs_start_ready_o;

  assign rs_valid_o = (cnt_q != 2'd0);
  assign rs_data_o  = fifo_mem[rd_ptr_q];
  assign pop        = rs_valid_o & rs_ready_i;

  // Words buffered plus in flight after this cycle's pop; keep at most 2 outstanding
  assign occ           = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign ram_rd_en_o   = (state_q == StIssue) & (occ < 3'd2);
  assign ram_rd_addr_o = compute_base + addrWidth'(off_q);

  assign done      = (state_q == StDrain) & (cnt_q == 2'd0) & ~inflight_q;
  assign rs_done_o = done;
  assign rs_busy_o = ~idle;

  // Read sequencer, bank select and swap bookkeeping
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      bank_sel_q <= 1'b0;
      ack_q      <= 1'b0;
      off_q      <= '0;
      rem_q      <= '0;
    end else begin
      ack_q <= swap_ack_o;
      if (swap_ack_o) begin
        bank_sel_q <= ~bank_sel_q;
      end
      unique case (state_q)
        StIdle: begin
          if (start_acc) begin
            off_q <= rs_base_i;
            rem_q <= rs_len_i;
            if ((rs_len_i == 16'd0) || start_oob) begin
              state_q <= StDrain;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (ram_rd_en_o) begin
            off_q <= off_q + bankAw'(Stride);
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO control: read data lands one cycle after issue
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= ram_rd_en_o;
      cnt_q      <= cnt_q + 2'(inflight_q) - 2'(pop);
      if (inflight_q) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // FIFO storage, no reset needed: entries are only read once marked valid
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_mem[wr_ptr_q] <= ram_data_i;
    end
  end

`ifdef ACTBUF_BOUNDS_CHECK_EN
  logic err_q;

  // Sticky error on any accepted out-of-bank request
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if ((ld_valid_i & ld_ready_o & ld_oob) | (wb_valid_i & wb_ready_o & wb_oob) |
                 (start_acc & start_oob)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_actbuf_pingpong_ctrl.sv
// Randomized bench for actbuf_pingpong_ctrl against a transaction-level reference model.
// The model follows ACTBUF_BOUNDS_CHECK_EN the same way the design does.
module tb_actbuf_pingpong_ctrl;

  localparam int B = 512;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         nrst;
  logic         ld_valid_i, ld_ready_o;
  logic [8:0]   ld_addr_i;
  logic [31:0]  ld_data_i;
  logic         wb_valid_i, wb_ready_o;
  logic [8:0]   wb_addr_i;
  logic [255:0] wb_data_i;
  logic         rs_start_i, rs_start_ready_o;
  logic [8:0]   rs_base_i;
  logic [15:0]  rs_len_i;
  logic         rs_valid_o, rs_ready_i;
  logic [255:0] rs_data_o;
  logic         rs_busy_o, rs_done_o;
  logic         swap_req_i, swap_ack_o, bank_sel_o;
  logic         ram_wr_en_1_o;
  logic [31:0]  ram_wr_addr_1_o;
  logic [31:0]  ram_wr_data_1_o;
  logic         ram_wr_en_2_o;
  logic [31:0]  ram_wr_addr_2_o;
  logic [255:0] ram_wr_data_2_o;
  logic         ram_rd_en_o;
  logic [31:0]  ram_rd_addr_o;
  logic [255:0] ram_data_i;
  logic         err_o;

  always #5 clk = ~clk;

  actbuf_pingpong_ctrl dut (
    .clk              (clk),
    .nrst             (nrst),
    .ld_valid_i       (ld_valid_i),
    .ld_ready_o       (ld_ready_o),
    .ld_addr_i        (ld_addr_i),
    .ld_data_i        (ld_data_i),
    .wb_valid_i       (wb_valid_i),
    .wb_ready_o       (wb_ready_o),
    .wb_addr_i        (wb_addr_i),
    .wb_data_i        (wb_data_i),
    .rs_start_i       (rs_start_i),
    .rs_start_ready_o (rs_start_ready_o),
    .rs_base_i        (rs_base_i),
    .rs_len_i         (rs_len_i),
    .rs_valid_o       (rs_valid_o),
    .rs_ready_i       (rs_ready_i),
    .rs_data_o        (rs_data_o),
    .rs_busy_o        (rs_busy_o),
    .rs_done_o        (rs_done_o),
    .swap_req_i       (swap_req_i),
    .swap_ack_o       (swap_ack_o),
    .bank_sel_o       (bank_sel_o),
    .ram_wr_en_1_o    (ram_wr_en_1_o),
    .ram_wr_addr_1_o  (ram_wr_addr_1_o),
    .ram_wr_data_1_o  (ram_wr_data_1_o),
    .ram_wr_en_2_o    (ram_wr_en_2_o),
    .ram_wr_addr_2_o  (ram_wr_addr_2_o),
    .ram_wr_data_2_o  (ram_wr_data_2_o),
    .ram_rd_en_o      (ram_rd_en_o),
    .ram_rd_addr_o    (ram_rd_addr_o),
    .ram_data_i       (ram_data_i),
    .err_o            (err_o)
  );

  // Reference model state
  typedef struct {
    logic [255:0] d;
    int           vis;
  } ent_t;

  int           n_vec = 0;
  int           n_err = 0;
  int           now;
  int           done_at;
  int           issue_from;
  bit           m_bank, m_busy, m_err, stream_on, last_ack;
  int unsigned  q_addr[$];
  ent_t         q_data[$];
  logic [255:0] next_ram;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_bank = 0; m_busy = 0; m_err = 0; stream_on = 0; last_ack = 0;
    done_at = -1; issue_from = 0; now = 0;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic idle_inputs();
    ld_valid_i = 0; wb_valid_i = 0; rs_start_i = 0; swap_req_i = 0; rs_ready_i = 1;
    ld_addr_i = '0; ld_data_i = '0; wb_addr_i = '0; wb_data_i = '0;
    rs_base_i = '0; rs_len_i = '0;
  endtask

  // One clock cycle: inputs already driven; check outputs, then advance the model
  task automatic step();
    bit e_ack, e_sr, e_wr1, e_wr2, e_valid, e_rd, pop, ld_oob, wb_oob, st_oob;
    int fill, comp;
    ent_t e;
    #1;
    ld_oob = 0; wb_oob = 0; st_oob = 0;
`ifdef ACTBUF_BOUNDS_CHECK_EN
    ld_oob = (int'(ld_addr_i) + 4) > B;
    wb_oob = (int'(wb_addr_i) + W) > B;
    st_oob = (int'(rs_base_i) + int'(rs_len_i) * W) > B;
`endif
    fill = m_bank ? 0 : B;
    comp = m_bank ? B : 0;
    e_ack = swap_req_i && !m_busy;
    e_sr  = !m_busy && !swap_req_i;
    check_val("swap_ack", swap_ack_o, e_ack);
    check_val("bank_sel", bank_sel_o, m_bank);
    check_val("ld_ready", ld_ready_o, !e_ack);
    check_val("wb_ready", wb_ready_o, !e_ack);
    check_val("start_ready", rs_start_ready_o, e_sr);
    e_wr1 = ld_valid_i && !e_ack && !ld_oob;
    e_wr2 = wb_valid_i && !e_ack && !wb_oob;
    check_val("wr_en_1", ram_wr_en_1_o, e_wr1);
    check_val("wr_en_2", ram_wr_en_2_o, e_wr2);
    if (e_wr1) begin
      check_val("wr_addr_1", ram_wr_addr_1_o, fill + int'(ld_addr_i));
      check_val("wr_data_1", ram_wr_data_1_o, ld_data_i);
    end
    if (e_wr2) begin
      check_val("wr_addr_2", ram_wr_addr_2_o, fill + int'(wb_addr_i));
      check_val("wr_data_2", ram_wr_data_2_o, wb_data_i);
    end
    e_valid = (q_data.size() > 0) && (q_data[0].vis <= now);
    check_val("rs_valid", rs_valid_o, e_valid);
    if (e_valid) check_val("rs_data", rs_data_o, q_data[0].d);
    pop  = e_valid && rs_ready_i;
    e_rd = (q_addr.size() > 0) && (now >= issue_from) && ((q_data.size() - int'(pop)) < 2);
    check_val("rd_en", ram_rd_en_o, e_rd);
    next_ram = rand256();
    if (e_rd) begin
      check_val("rd_addr", ram_rd_addr_o, q_addr[0]);
      void'(q_addr.pop_front());
      e.d   = next_ram;
      e.vis = now + 2;
      q_data.push_back(e);
    end
    if (pop) begin
      void'(q_data.pop_front());
      if (stream_on && q_addr.size() == 0 && q_data.size() == 0) done_at = now + 1;
    end
    check_val("rs_done", rs_done_o, done_at == now);
    check_val("rs_busy", rs_busy_o, m_busy);
    check_val("err", err_o, m_err);
    // state seen from the next cycle on
    if (done_at == now) begin
      m_busy = 0;
      stream_on = 0;
    end
    if (rs_start_i && e_sr) begin
      m_busy = 1;
      stream_on = 1;
      if (rs_len_i == 0 || st_oob) begin
        done_at = now + 1;
        if (st_oob) m_err = 1;
      end else begin
        for (int i = 0; i < int'(rs_len_i); i++)
          q_addr.push_back(comp + ((int'(rs_base_i) + i * W) % B));
        issue_from = now + 1;
      end
    end
    if (ld_valid_i && !e_ack && ld_oob) m_err = 1;
    if (wb_valid_i && !e_ack && wb_oob) m_err = 1;
    if (e_ack) m_bank = !m_bank;
    last_ack = e_ack;
    now++;
    @(negedge clk);
    ram_data_i = next_ram;
  endtask

  task automatic do_reset();
    nrst = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("rst_bank_sel", bank_sel_o, 1'b0);
    check_val("rst_ld_ready", ld_ready_o, 1'b1);
    check_val("rst_rs_valid", rs_valid_o, 1'b0);
    check_val("rst_rs_busy", rs_busy_o, 1'b0);
    check_val("rst_rs_done", rs_done_o, 1'b0);
    check_val("rst_rd_en", ram_rd_en_o, 1'b0);
    check_val("rst_err", err_o, 1'b0);
    nrst = 1;
    model_reset();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if (swap_req_i && last_ack) swap_req_i = 0;
      else if (!swap_req_i && $urandom_range(0, 15) == 0) swap_req_i = 1;
      ld_valid_i = $urandom_range(0, 1);
      ld_addr_i  = 9'($urandom_range(0, 511));
      ld_data_i  = $urandom;
      wb_valid_i = $urandom_range(0, 1);
      wb_addr_i  = 9'($urandom_range(0, 511));
      wb_data_i  = rand256();
      rs_start_i = ($urandom_range(0, 3) == 0);
      rs_base_i  = 9'($urandom_range(0, 511));
      rs_len_i   = 16'($urandom_range(0, 6));
      rs_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  initial begin
    ram_data_i = '0;
    do_reset();

    // loader write into FILL bank 1 half: offset 4 -> 516
    ld_valid_i = 1; ld_addr_i = 9'd4; ld_data_i = 32'h11223344;
    step();
    // offset at the bank edge
    ld_addr_i = 9'd510;
    step();
    ld_valid_i = 0;
    step();

    // zero-length stream
    rs_start_i = 1; rs_base_i = 9'd0; rs_len_i = 16'd0;
    step();
    rs_start_i = 0;
    repeat (3) step();

    // 8-word stream with a swap request raised while it runs
    rs_start_i = 1; rs_base_i = 9'd40; rs_len_i = 16'd8; rs_ready_i = 1;
    step();
    rs_start_i = 0;
    step();
    swap_req_i = 1;
    for (int i = 0; i < 40; i++) begin
      if (last_ack) swap_req_i = 0;
      step();
    end
    swap_req_i = 0;

    // stream from bank 1 with a toggling consumer
    rs_start_i = 1; rs_base_i = 9'd0; rs_len_i = 16'd4;
    step();
    rs_start_i = 0;
    for (int i = 0; i < 30; i++) begin
      rs_ready_i = i[0];
      step();
    end

    run_random(2000);
    do_reset();
    run_random(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
